// File: rtl/cache_types.sv
// Shared types for the N-way cache controller: datapath mux selects and FSM states.
package cache_types;

   typedef enum logic {
      D_CPU = 1'b0,
      D_LLC = 1'b1
   } datamux_t;

   typedef enum logic {
      P_CPU   = 1'b0,
      P_CACHE = 1'b1
   } pmadmux_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMP   = 2'd1,
      EVICT = 2'd2,
      LOAD  = 2'd3
   } cache_nway_state_t;

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU: next-state bits for an access and the victim the current bits point at.
// Node 0 is the root, children of node i are 2i+1/2i+2; a 0 bit points the victim left.
module cache_plru #(
   parameter  int WAYS   = 4,
   localparam int WAY_W  = $clog2(WAYS),
   localparam int PLRU_W = WAYS - 1
) (
   input  logic [PLRU_W-1:0] plru_in,
   input  logic [WAY_W-1:0]  access_way,
   output logic [PLRU_W-1:0] plru_next,
   output logic [WAY_W-1:0]  victim_way
);

   // Walk root to leaf; the way index MSB picks the branch at the root.
   always_comb begin
      int                node;
      logic [WAY_W-1:0]  way_shift;
      logic [PLRU_W-1:0] bit_mask;
      plru_next = plru_in;
      node      = 0;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         way_shift = access_way >> l;
         bit_mask  = PLRU_W'(1) << node;
         plru_next = way_shift[0] ? (plru_next & ~bit_mask) : (plru_next | bit_mask);
         node      = 2 * node + 1 + (way_shift[0] ? 1 : 0);
      end
   end

   always_comb begin
      int                node;
      logic [PLRU_W-1:0] p_shift;
      victim_way = '0;
      node       = 0;
      for (int l = 0; l < WAY_W; l++) begin
         p_shift    = plru_in >> node;
         victim_way = (victim_way << 1) | WAY_W'(p_shift[0]);
         node       = 2 * node + 1 + (p_shift[0] ? 1 : 0);
      end
   end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way write-back, write-allocate cache with tree-PLRU replacement.
// Handshake: mem_read/mem_write are held by the CPU until the one-cycle mem_resp; pmem_read/pmem_write are held until pmem_resp.
module cache_control_nway
   import cache_types::*;
#(
   parameter  int WAYS   = 4,
   localparam int WAY_W  = $clog2(WAYS),
   localparam int PLRU_W = WAYS - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic              mem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   input  logic              pmem_resp,
   input  logic [WAYS-1:0]   hit_way,
   input  logic [WAYS-1:0]   valid_way,
   input  logic [WAYS-1:0]   dirty_way,
   input  logic [PLRU_W-1:0] plru_in,
   output logic [PLRU_W-1:0] plru_out,
   output logic              ld_plru,
   output logic [WAYS-1:0]   ld_valid,
   output logic [WAYS-1:0]   ld_dirty,
   output logic [WAYS-1:0]   ld_tag,
   output logic [WAYS-1:0]   ld_data,
   output logic              dirty_val,
   output datamux_t          datamux,
   output pmadmux_t          pmadmux,
   output logic [WAY_W-1:0]  way_sel,
   output logic              perf_start,
   output logic              perf_end,
   output logic              perf_miss,
   output logic              perf_wb,
   output cache_nway_state_t state_dbg
);

   cache_nway_state_t state_q;
   logic [WAY_W-1:0]  victim_q;
   logic [WAY_W-1:0]  hit_idx, inv_idx, plru_victim, miss_victim, access_way;
   logic [WAYS-1:0]   hit_oh, victim_oh;
   logic [PLRU_W-1:0] plru_next;

   // Lowest index wins for both multi-hit and invalid-way-first allocation.
   always_comb begin
      hit_idx = '0;
      inv_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit_way[i])    hit_idx = WAY_W'(i);
         if (!valid_way[i]) inv_idx = WAY_W'(i);
      end
   end

   assign miss_victim = (&valid_way) ? plru_victim : inv_idx;
   assign access_way  = (state_q == CMP) ? hit_idx : victim_q;
   assign hit_oh      = WAYS'(1) << hit_idx;
   assign victim_oh   = WAYS'(1) << victim_q;
   assign state_dbg   = state_q;

   cache_plru #(.WAYS(WAYS)) u_plru (
      .plru_in    (plru_in),
      .access_way (access_way),
      .plru_next  (plru_next),
      .victim_way (plru_victim)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         victim_q <= '0;
      end else begin
         unique case (state_q)
            IDLE:  if (mem_read || mem_write) state_q <= CMP;
            CMP: begin
               if (|hit_way) begin
                  state_q <= IDLE;
               end else begin
                  victim_q <= miss_victim;
                  state_q  <= (valid_way[miss_victim] && dirty_way[miss_victim]) ? EVICT : LOAD;
               end
            end
            EVICT: if (pmem_resp) state_q <= LOAD;
            LOAD:  if (pmem_resp) state_q <= CMP;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      plru_out   = '0;
      ld_plru    = 1'b0;
      ld_valid   = '0;
      ld_dirty   = '0;
      ld_tag     = '0;
      ld_data    = '0;
      dirty_val  = 1'b0;
      datamux    = D_CPU;
      pmadmux    = P_CPU;
      way_sel    = '0;
      perf_start = 1'b0;
      perf_end   = 1'b0;
      perf_miss  = 1'b0;
      perf_wb    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: perf_start = mem_read | mem_write;
            CMP: begin
               way_sel = hit_idx;
               if (|hit_way) begin
                  mem_resp = 1'b1;
                  perf_end = 1'b1;
                  ld_plru  = 1'b1;
                  plru_out = plru_next;
                  // Read+write together is handled as a write.
                  if (mem_write) begin
                     ld_data   = hit_oh;
                     ld_dirty  = hit_oh;
                     dirty_val = 1'b1;
                  end
               end else begin
                  perf_miss = 1'b1;
               end
            end
            EVICT: begin
               way_sel    = victim_q;
               pmadmux    = P_CACHE;
               pmem_write = 1'b1;
               perf_wb    = pmem_resp;
            end
            LOAD: begin
               way_sel   = victim_q;
               pmem_read = 1'b1;
               datamux   = D_LLC;
               if (pmem_resp) begin
                  ld_tag   = victim_oh;
                  ld_valid = victim_oh;
                  ld_data  = victim_oh;
                  ld_dirty = victim_oh;
               end
            end
            default: ;
         endcase
      end
   end

   a_single_hit: assert property (@(posedge clk) disable iff (rst) (state_q == CMP) |-> $onehot0(hit_way));

endmodule
